// File: rtl/imem_loader.sv
// imem_loader: write-side agent for the byte-addressed, little-endian
// instruction memory. It accepts 32-bit words on a valid/ready stream and
// writes each word as four bytes at consecutive addresses. The core is held
// while a load runs. The load ends with DONE when the HALT word (0x0000007F)
// has been written, or with ERR when memory fills without a HALT word.
//
// Ports:
//   clk, rst     rising-edge clock, asynchronous active-high reset
//   load_start   one-cycle pulse; starts a load at byte 0 (from IDLE/DONE/ERR)
//   in_valid/in_ready/in_word   instruction word stream
//   mem_we/mem_addr/mem_wdata   byte write port to instruction memory
//   core_hold    stalls the core while loading, and after an overflow
//   load_done    sticky; HALT word written
//   load_err     sticky; memory filled without a HALT word
//   word_count   words fully written in the current load
module imem_loader #(
  parameter int MEM_BYTES = 128,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [7:0]       mem_wdata,
  output logic             core_hold,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] word_count
);

  localparam int          AW   = $clog2(MEM_BYTES);
  localparam logic [31:0] HALT = 32'h0000_007F;

  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, ERR} state_t;

  state_t        state;
  logic [AW-1:0] base;
  logic [1:0]    idx;
  logic [31:0]   word;
  logic [AW-1:0] byte_addr;
  logic          last_slot;

  // The address and data are taken straight from the registers, so they
  // return to 0 on reset together with the state.
  assign byte_addr = base + AW'(idx);
  assign mem_addr  = 32'(byte_addr);
  assign mem_wdata = word[{idx, 3'b000} +: 8];

  // Use one extra bit because base+4 equals MEM_BYTES in the last slot.
  assign last_slot = (({1'b0, base} + (AW+1)'(4)) == (AW+1)'(MEM_BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      base       <= '0;
      idx        <= '0;
      word       <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      core_hold  <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        // IDLE, DONE and ERR restart the same way. load_start is not
        // checked in ACCEPT or WRITE, so a running load is never restarted.
        IDLE, DONE, ERR: begin
          if (load_start) begin
            state      <= ACCEPT;
            base       <= '0;
            idx        <= '0;
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            in_ready   <= 1'b1;
            core_hold  <= 1'b1;
          end
        end
        ACCEPT: begin
          if (in_valid && in_ready) begin
            state    <= WRITE;
            word     <= in_word;
            idx      <= '0;
            in_ready <= 1'b0;
            mem_we   <= 1'b1;
          end
        end
        WRITE: begin
          if (idx == 2'd3) begin
            mem_we     <= 1'b0;
            idx        <= '0;
            base       <= base + AW'(4);
            word_count <= word_count + CNT_W'(1);
            // A HALT word in the last slot still ends with DONE.
            if (word == HALT) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
            end else if (last_slot) begin
              // Keep the core held. It must not run a truncated program.
              state    <= ERR;
              load_err <= 1'b1;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
            end
          end else begin
            idx <= idx + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader. It keeps its own byte-memory model, which
// is filled from the write port on each rising edge, and checks it against
// hand-computed values.
module tb_imem_loader;

  localparam int MB = 128;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_word = '0;
  logic          in_ready, mem_we, core_hold, load_done, load_err;
  logic [31:0]   mem_addr;
  logic [7:0]    mem_wdata;
  logic [CW-1:0] word_count;

  imem_loader #(.MEM_BYTES(MB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .load_start(load_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .load_done(load_done), .load_err(load_err),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [MB];
  int          we_cnt = 0;
  int          hs_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Memory model: a byte is written on each rising edge where mem_we is high.
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_addr < MB) mem[mem_addr[6:0]] = mem_wdata;
      last_addr = mem_addr;
      last_data = mem_wdata;
      we_cnt++;
    end
    if (in_valid && in_ready) hs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic fill();
    for (int i = 0; i < MB; i++) mem[i] = 8'hAA;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  // Drive a word and wait until in_ready is high. The handshake happens on
  // the next edge, and the task returns at the falling edge after it.
  task automatic send_word(input logic [31:0] w);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(load_done || load_err) && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("end_seen", 32'(load_done | load_err), 32'd1);
  endtask

  logic [7:0] bexp [12] = '{8'h93, 8'h02, 8'h10, 8'h00, 8'h93, 8'h03, 8'h10, 8'h00,
                            8'h7F, 8'h00, 8'h00, 8'h00};
  logic [7:0] bpexp [4] = '{8'h63, 8'h82, 8'h64, 8'h02};
  int hs0, we0;

  initial begin
    fill();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a cycle with random inputs.
    pulse_start();
    in_valid = 1'($urandom_range(0, 1));
    in_word  = $urandom;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_core_hold",  32'(core_hold),  32'd0);
    chk("rst_load_done",  32'(load_done),  32'd0);
    chk("rst_load_err",   32'(load_err),   32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    chk("rst_mem_addr",   mem_addr,        32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_hold", 32'(core_hold), 32'd0);

    // Basic three-word load.
    fill();
    we_cnt = 0;
    pulse_start();
    send_word(32'h0010_0293);
    send_word(32'h0010_0393);
    send_word(32'h0000_007F);
    in_valid = 1'b0;
    wait_end();
    for (int i = 0; i < 12; i++) chk($sformatf("basic_byte%0d", i), 32'(mem[i]), 32'(bexp[i]));
    chk("basic_we_cnt", 32'(we_cnt),     32'd12);
    chk("basic_done",   32'(load_done),  32'd1);
    chk("basic_err",    32'(load_err),   32'd0);
    chk("basic_hold",   32'(core_hold),  32'd0);
    chk("basic_wc",     32'(word_count), 32'd3);

    // Backpressure: in_valid stays high through WRITE.
    fill();
    pulse_start();
    hs0 = hs_cnt;
    in_valid = 1'b1;
    in_word  = 32'h0264_8263;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("bp_ready_low", 32'(in_ready), 32'd0);
      chk("bp_we_high",   32'(mem_we),   32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_once", 32'(hs_cnt - hs0), 32'd1);
    we0 = we_cnt;
    repeat (10) begin
      @(negedge clk);
      chk("bp_idle_hold", 32'(core_hold), 32'd1);
    end
    chk("bp_no_we", 32'(we_cnt - we0), 32'd0);
    send_word(32'h0000_007F);
    in_valid = 1'b0;
    wait_end();
    chk("bp_wc", 32'(word_count), 32'd2);
    for (int i = 0; i < 4; i++) chk($sformatf("bp_byte%0d", i), 32'(mem[i]), 32'(bpexp[i]));

    // Overflow: 32 words and no HALT.
    fill();
    we_cnt = 0;
    pulse_start();
    for (int i = 0; i < 32; i++) send_word(32'h0000_0013);
    in_valid = 1'b0;
    wait_end();
    chk("ovf_last_addr", last_addr,          32'd127);
    chk("ovf_last_data", 32'(last_data),     32'd0);
    chk("ovf_byte124",   32'(mem[124]),      32'h13);
    chk("ovf_we_cnt",    32'(we_cnt),        32'd128);
    chk("ovf_err",       32'(load_err),      32'd1);
    chk("ovf_done",      32'(load_done),     32'd0);
    chk("ovf_wc",        32'(word_count),    32'd32);
    chk("ovf_hold",      32'(core_hold),     32'd1);
    chk("ovf_ready",     32'(in_ready),      32'd0);

    // HALT word in the final slot.
    fill();
    pulse_start();
    for (int i = 0; i < 31; i++) send_word(32'h0000_0013);
    send_word(32'h0000_007F);
    in_valid = 1'b0;
    wait_end();
    chk("fin_done",    32'(load_done),  32'd1);
    chk("fin_err",     32'(load_err),   32'd0);
    chk("fin_wc",      32'(word_count), 32'd32);
    chk("fin_byte124", 32'(mem[124]),   32'h7F);

    // Reset while byte 2 of word 1 is being written.
    fill();
    pulse_start();
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_addr6", mem_addr, 32'd6);
    rst = 1'b1;
    #1;
    chk("mid_we",   32'(mem_we),    32'd0);
    chk("mid_hold", 32'(core_hold), 32'd0);
    chk("mid_addr", mem_addr,       32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_byte0", 32'(mem[0]), 32'h44);
    chk("mid_byte4", 32'(mem[4]), 32'h88);
    chk("mid_byte5", 32'(mem[5]), 32'h77);
    chk("mid_byte6", 32'(mem[6]), 32'hAA);
    chk("mid_byte7", 32'(mem[7]), 32'hAA);
    pulse_start();
    chk("mid_re_wc",    32'(word_count), 32'd0);
    chk("mid_re_ready", 32'(in_ready),   32'd1);
    send_word(32'h0000_007F);
    in_valid = 1'b0;
    chk("mid_re_addr", mem_addr,     32'd0);
    chk("mid_re_we",   32'(mem_we),  32'd1);
    wait_end();
    chk("mid_re_done", 32'(load_done),  32'd1);
    chk("mid_re_wc1",  32'(word_count), 32'd1);

    // Reload from DONE.
    pulse_start();
    chk("rl_done_clr", 32'(load_done), 32'd0);
    in_valid = 1'b1;
    in_word  = 32'h0000_007F;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rl_first_we",   32'(mem_we), 32'd1);
    chk("rl_first_addr", mem_addr,    32'd0);
    wait_end();
    chk("rl_done", 32'(load_done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
